// File: rtl/magic_buttons.sv
// rtl/magic_buttons.sv - front-panel Magic/Pause button conditioning for the NMI controller
// Synchronizes, debounces and frame-latches button and hotkey requests; long Magic press yields reboot.
module magic_buttons #(
  parameter int DEBOUNCE_CYCLES   = 280000,
  parameter int LONG_PRESS_FRAMES = 100
) (
  input  logic rst_n,
  input  logic clk28,
  input  logic n_int,
  input  logic n_int_next,
  input  logic btn_magic_n,
  input  logic btn_pause_n,
  input  logic kbd_magic,
  input  logic kbd_pause,
  output logic magic_button,
  output logic pause_button,
  output logic reboot_req,
  output logic magic_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    LP_LAST = 8'(LONG_PRESS_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  // index 0 = Magic, index 1 = Pause; all button levels are active-low
  logic [1:0]         raw, sync1, synced, stable, stable_d, stable_nxt;
  logic [1:0][CW-1:0] db_cnt, cnt_nxt;

  state_t     state, state_nxt;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic       frame_evt;
  logic       m_press, m_release, p_press;
  logic       short_rel, reboot_nxt;
  logic       magic_nxt, pause_nxt;

  assign raw       = {btn_pause_n, btn_magic_n};
  assign frame_evt = n_int & ~n_int_next;

  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = db_cnt;
    for (int i = 0; i < 2; i++) begin
      if (synced[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (db_cnt[i] == DB_LAST) begin
        stable_nxt[i] = synced[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = db_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '1;
      synced     <= '1;
      stable     <= '1;
      stable_d   <= '1;
      db_cnt     <= '0;
      magic_held <= 1'b0;
    end else begin
      sync1      <= raw;
      synced     <= sync1;
      stable     <= stable_nxt;
      stable_d   <= stable;
      db_cnt     <= cnt_nxt;
      magic_held <= ~stable_nxt[0];
    end
  end

  // Edges are taken from the registered stable state, so the FSM acts one cycle after debounce
  assign m_press   = stable_d[0] & ~stable[0];
  assign m_release = ~stable_d[0] & stable[0];
  assign p_press   = stable_d[1] & ~stable[1];

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    short_rel     = 1'b0;
    reboot_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (m_press) begin
          state_nxt     = PRESSED;
          frame_cnt_nxt = 8'd0;
        end
      end
      PRESSED: begin
        if (m_release) begin
          short_rel = (frame_cnt < LP_LAST);
          state_nxt = IDLE;
        end else if (frame_evt) begin
          frame_cnt_nxt = frame_cnt + 8'd1;
          if (frame_cnt_nxt == LP_LAST) begin
            reboot_nxt = 1'b1;
            state_nxt  = LONG;
          end
        end
      end
      LONG: begin
        if (m_release) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Requests survive until a frame edge has been seen; a new set in that cycle wins
  always_comb begin
    magic_nxt = magic_button;
    pause_nxt = pause_button;
    if (short_rel || kbd_magic)           magic_nxt = 1'b1;
    else if (frame_evt && magic_button)   magic_nxt = 1'b0;
    if (p_press || kbd_pause)             pause_nxt = 1'b1;
    else if (frame_evt && pause_button)   pause_nxt = 1'b0;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_cnt    <= 8'd0;
      magic_button <= 1'b0;
      pause_button <= 1'b0;
      reboot_req   <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_cnt    <= frame_cnt_nxt;
      magic_button <= magic_nxt;
      pause_button <= pause_nxt;
      reboot_req   <= reboot_nxt;
    end
  end

endmodule

// File: tb/tb_magic_buttons.sv
// tb/tb_magic_buttons.sv - directed self-checking bench for magic_buttons
// Table of per-cycle vectors with frames off, then frame-aligned hand sequences.
module tb_magic_buttons;

  logic rst_n, clk28, n_int, n_int_next;
  logic btn_magic_n, btn_pause_n, kbd_magic, kbd_pause;
  logic magic_button, pause_button, reboot_req, magic_held;

  magic_buttons #(.DEBOUNCE_CYCLES(8), .LONG_PRESS_FRAMES(4)) dut (
    .rst_n(rst_n), .clk28(clk28), .n_int(n_int), .n_int_next(n_int_next),
    .btn_magic_n(btn_magic_n), .btn_pause_n(btn_pause_n),
    .kbd_magic(kbd_magic), .kbd_pause(kbd_pause),
    .magic_button(magic_button), .pause_button(pause_button),
    .reboot_req(reboot_req), .magic_held(magic_held)
  );

  typedef struct {
    logic bm, bp, km, kp;
    int   cycles;
    logic e_held, e_mb, e_pb, e_rb;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   fcnt = 0;
  logic frame_en = 1'b0;
  vec_t vq[$];

  initial begin
    clk28 = 1'b0;
    forever #5 clk28 = ~clk28;
  end

  // frame_evt once every 100 cycles while enabled
  initial begin
    n_int = 1'b1;
    n_int_next = 1'b1;
    forever begin
      @(posedge clk28);
      #1;
      fcnt = (fcnt == 99) ? 0 : fcnt + 1;
      n_int_next = !(frame_en && fcnt == 99);
      n_int = !(frame_en && fcnt == 0);
    end
  end

  function automatic logic fe();
    return n_int && !n_int_next;
  endfunction

  task automatic step();
    @(posedge clk28);
    #2;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got nothing expected event at %0t", name, $time);
  endtask

  task automatic chk_all(input string tag, input logic eh, input logic emb, input logic epb, input logic erb);
    chk({tag, "_held"}, magic_held, eh);
    chk({tag, "_mb"}, magic_button, emb);
    chk({tag, "_pb"}, pause_button, epb);
    chk({tag, "_rb"}, reboot_req, erb);
  endtask

  task automatic add_v(input logic bm, input logic bp, input logic km, input logic kp, input int n,
                       input logic eh, input logic emb, input logic epb, input logic erb);
    vec_t v;
    v.bm = bm; v.bp = bp; v.km = km; v.kp = kp; v.cycles = n;
    v.e_held = eh; v.e_mb = emb; v.e_pb = epb; v.e_rb = erb;
    vq.push_back(v);
  endtask

  task automatic wait_frame(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 150 && !ok; i++) begin
      step();
      if (fe()) ok = 1;
    end
    if (!ok) tmo(name);
  endtask

  initial begin
    bit   ok;
    int   fe_cnt, rb_cnt, rb_cyc, exp_rb_cyc, cyc;

    // btn_m btn_p kbd_m kbd_p cycles | held mb pb rb
    add_v(1, 1, 0, 0,  4,  0, 0, 0, 0);
    add_v(0, 1, 0, 0,  5,  0, 0, 0, 0);
    add_v(1, 1, 0, 0, 12,  0, 0, 0, 0);
    add_v(0, 1, 0, 0,  7,  0, 0, 0, 0);
    add_v(1, 1, 0, 0, 12,  0, 0, 0, 0);
    add_v(1, 0, 0, 0, 10,  0, 0, 0, 0);
    add_v(1, 0, 0, 0,  3,  0, 0, 1, 0);
    add_v(1, 1, 0, 0, 12,  0, 0, 1, 0);
    add_v(1, 1, 0, 1,  1,  0, 0, 1, 0);
    add_v(1, 1, 1, 0,  1,  0, 1, 1, 0);
    add_v(1, 1, 0, 0,  5,  0, 1, 1, 0);
    add_v(0, 1, 0, 0,  9,  0, 1, 1, 0);
    add_v(0, 1, 0, 0,  6,  1, 1, 1, 0);
    add_v(1, 1, 0, 0,  9,  1, 1, 1, 0);
    add_v(1, 1, 0, 0,  4,  0, 1, 1, 0);

    rst_n = 1'b0;
    btn_magic_n = 1'b1; btn_pause_n = 1'b1; kbd_magic = 1'b0; kbd_pause = 1'b0;
    repeat (3) step();
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      btn_magic_n = vq[i].bm; btn_pause_n = vq[i].bp;
      kbd_magic = vq[i].km;   kbd_pause = vq[i].kp;
      for (int c = 0; c < vq[i].cycles; c++) begin
        step();
        chk_all($sformatf("vec%0d_c%0d", i, c), vq[i].e_held, vq[i].e_mb, vq[i].e_pb, vq[i].e_rb);
      end
    end
    kbd_magic = 1'b0; kbd_pause = 1'b0;

    // Reset with Magic physically held; then a long press of 5 frames
    frame_en = 1'b1;
    #1 rst_n = 1'b0;
    btn_magic_n = 1'b0;
    #1 chk_all("rst_async", 0, 0, 0, 0);
    repeat (3) begin
      step();
      chk_all("rst_hold", 0, 0, 0, 0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("held_pre_%0d", i), magic_held, 1'b0);
    end
    step();
    chk("held_at_10", magic_held, 1'b1);

    fe_cnt = 0; rb_cnt = 0; rb_cyc = -1; exp_rb_cyc = -2; cyc = 0;
    while (fe_cnt < 5 && cyc < 700) begin
      step();
      cyc++;
      chk("long_mb", magic_button, 1'b0);
      if (reboot_req) begin
        rb_cnt++;
        rb_cyc = cyc;
      end
      if (fe()) begin
        fe_cnt++;
        if (fe_cnt == 4) exp_rb_cyc = cyc + 1;
      end
    end
    if (fe_cnt < 5) tmo("long_frames");
    chk("long_rb_once", rb_cnt == 1, 1'b1);
    chk("long_rb_cycle", rb_cyc == exp_rb_cyc, 1'b1);
    btn_magic_n = 1'b1;
    repeat (30) begin
      step();
      chk("long_rel_mb", magic_button, 1'b0);
      chk("long_rel_rb", reboot_req, 1'b0);
    end
    chk("long_rel_held", magic_held, 1'b0);

    // Short press spanning 2 frames
    btn_magic_n = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (magic_held) ok = 1;
    end
    if (!ok) tmo("short_press_held");
    fe_cnt = 0;
    for (int i = 0; i < 300 && fe_cnt < 2; i++) begin
      step();
      chk("short_rb", reboot_req, 1'b0);
      chk("short_mb_hold", magic_button, 1'b0);
      if (fe()) fe_cnt++;
    end
    if (fe_cnt < 2) tmo("short_frames");
    btn_magic_n = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (!magic_held) ok = 1;
    end
    if (!ok) tmo("short_release_held");
    chk("short_mb_at_rel", magic_button, 1'b0);
    step();
    chk("short_mb_rise", magic_button, 1'b1);
    ok = 0;
    for (int i = 0; i < 150 && !ok; i++) begin
      step();
      chk("short_mb_until_frame", magic_button, 1'b1);
      chk("short_rb2", reboot_req, 1'b0);
      if (fe()) ok = 1;
    end
    if (!ok) tmo("short_clear_frame");
    step();
    chk("short_mb_clear", magic_button, 1'b0);

    // kbd_pause in the frame_evt cycle itself
    wait_frame("pause_frame", ok);
    chk("pause_pre", pause_button, 1'b0);
    kbd_pause = 1'b1;
    step();
    kbd_pause = 1'b0;
    chk("pause_set_on_frame", pause_button, 1'b1);
    ok = 0;
    for (int i = 0; i < 150 && !ok; i++) begin
      step();
      chk("pause_hold", pause_button, 1'b1);
      if (fe()) ok = 1;
    end
    if (!ok) tmo("pause_clear_frame");
    step();
    chk("pause_clear", pause_button, 1'b0);

    // Two hotkey strobes plus a short press merge into one request
    wait_frame("merge_frame", ok);
    repeat (5) step();
    kbd_magic = 1'b1;
    step();
    kbd_magic = 1'b0;
    chk("merge_kbd1", magic_button, 1'b1);
    repeat (10) step();
    kbd_magic = 1'b1;
    step();
    kbd_magic = 1'b0;
    chk("merge_kbd2", magic_button, 1'b1);
    btn_magic_n = 1'b0;
    repeat (15) begin
      step();
      chk("merge_press", magic_button, 1'b1);
    end
    btn_magic_n = 1'b1;
    repeat (15) begin
      step();
      chk("merge_release", magic_button, 1'b1);
    end
    ok = 0;
    for (int i = 0; i < 150 && !ok; i++) begin
      step();
      chk("merge_hold", magic_button, 1'b1);
      if (fe()) ok = 1;
    end
    if (!ok) tmo("merge_clear_frame");
    step();
    chk("merge_clear", magic_button, 1'b0);
    repeat (20) begin
      step();
      chk("merge_single", magic_button, 1'b0);
    end

    // Asynchronous reset while a request is pending
    kbd_magic = 1'b1;
    step();
    kbd_magic = 1'b0;
    chk("rst_pre_mb", magic_button, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_all("rst_mid_request", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
